bounce_gen: RTL and testbench

//  Synthesizable mechanical-switch emulator; transmit-side counterpart of the debouncer.

---
 rtl/bounce_gen.sv | 132 +++++++++++++
 tb/tb_bounce_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// Mechanical-switch emulator: turns a clean level into an odd burst of LFSR-timed glitches plus a settle hold.
// Optional BOUNCE_RELEASE_EN: release events (toward IDLE_LEVEL) also burst; otherwise they produce one clean edge.
module bounce_gen #(
    parameter int unsigned BOUNCE_MAX_EDGES = 8,
    parameter int unsigned GLITCH_MAX_CYC   = 4,
    parameter int unsigned SETTLE_CYC       = 16,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    parameter logic        IDLE_LEVEL       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic       data_out,
    output logic       busy,
    output logic [4:0] bounce_edges
);

    localparam int unsigned REM_MAX   = 2 * BOUNCE_MAX_EDGES - 1;
    localparam int unsigned REM_W     = (REM_MAX > 1) ? $clog2(REM_MAX + 1) : 1;
    localparam int unsigned CNT_MAX   = (SETTLE_CYC > GLITCH_MAX_CYC) ? SETTLE_CYC : GLITCH_MAX_CYC;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [4:0]  EDGE_SAT  = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TOGGLE,
        S_HOLD,
        S_SETTLE
    } state_t;

    state_t           state, state_n;
    logic             data_out_n;
    logic             busy_n;
    logic [4:0]       edges_n;
    logic [15:0]      lfsr, lfsr_n;
    logic [REM_W-1:0] remaining, remaining_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      k_draw;
    logic [31:0]      l_draw;

    // Galois right-shift step; advanced only when a draw is consumed
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    assign k_draw = 32'(lfsr[7:0]) % BOUNCE_MAX_EDGES;
    assign l_draw = 32'(lfsr[3:0]) % GLITCH_MAX_CYC + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            data_out     <= IDLE_LEVEL;
            busy         <= 1'b0;
            bounce_edges <= '0;
            lfsr         <= LFSR_SEED;
            remaining    <= '0;
            cnt          <= '0;
        end else begin
            state        <= state_n;
            data_out     <= data_out_n;
            busy         <= busy_n;
            bounce_edges <= edges_n;
            lfsr         <= lfsr_n;
            remaining    <= remaining_n;
            cnt          <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        data_out_n  = data_out;
        edges_n     = bounce_edges;
        lfsr_n      = lfsr;
        remaining_n = remaining;
        cnt_n       = cnt;

        case (state)
            S_IDLE: begin
                if (data_in != data_out) begin
                    state_n = S_TOGGLE;
                    edges_n = '0;
`ifdef BOUNCE_RELEASE_EN
                    remaining_n = REM_W'(2 * k_draw + 32'd1);
                    lfsr_n      = lfsr_step(lfsr);
`else
                    // release toward idle is a single clean edge with no draw
                    if (data_in == IDLE_LEVEL) begin
                        remaining_n = REM_W'(1);
                    end else begin
                        remaining_n = REM_W'(2 * k_draw + 32'd1);
                        lfsr_n      = lfsr_step(lfsr);
                    end
`endif
                end
            end
            S_TOGGLE: begin
                data_out_n  = ~data_out;
                remaining_n = remaining - REM_W'(1);
                if (bounce_edges != EDGE_SAT) begin
                    edges_n = bounce_edges + 5'd1;
                end
                if (remaining <= REM_W'(1)) begin
                    state_n = S_SETTLE;
                    cnt_n   = CNT_W'(SETTLE_CYC);
                end else begin
                    state_n = S_HOLD;
                    cnt_n   = CNT_W'(l_draw);
                    lfsr_n  = lfsr_step(lfsr);
                end
            end
            S_HOLD: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_n = S_TOGGLE;
                end
            end
            S_SETTLE: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: event schedules predicted from an LFSR reference model.
// Honours BOUNCE_RELEASE_EN when predicting release events.
module tb_bounce_gen;

    localparam int SETTLE = 16;
    localparam int KMAX   = 8;
    localparam int GMAX   = 4;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef BOUNCE_RELEASE_EN
    localparam bit REL_BURST = 1'b1;
`else
    localparam bit REL_BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       data_in, data_out, busy;
    logic [4:0] bounce_edges;
    logic       data_in1, data_out1, busy1;
    logic [4:0] bounce_edges1;

    always #5 clk = ~clk;

    bounce_gen dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_out     (data_out),
        .busy         (busy),
        .bounce_edges (bounce_edges)
    );

    bounce_gen #(
        .BOUNCE_MAX_EDGES (1),
        .SETTLE_CYC       (4)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in1),
        .data_out     (data_out1),
        .busy         (busy1),
        .bounce_edges (bounce_edges1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tog_q[$], fall_q[$], exp_tog[$], exp_fall[$], rel3[$];
    logic [15:0] m_lfsr;
    int m_edges, m_last_fall;
    logic prev_out  = 1'b1;
    logic prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // record the cycle of every data_out change and busy falling edge
    always @(negedge clk) begin
        if (!$isunknown(data_out) && data_out !== prev_out) tog_q.push_back(cyc);
        if (prev_busy === 1'b1 && busy === 1'b0) fall_q.push_back(cyc);
        prev_out  <= data_out;
        prev_busy <= busy;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [15:0] step(input logic [15:0] x);
        return (x >> 1) ^ ({16{x[0]}} & 16'hB400);
    endfunction

    task automatic clear_q();
        tog_q.delete();
        fall_q.delete();
        exp_tog.delete();
        exp_fall.delete();
    endtask

    // expected toggle edges for an event whose trigger edge is t
    task automatic model_event(input int t, input bit burst);
        int k, e, l;
        k = 0;
        if (burst) begin
            k = int'(m_lfsr[7:0]) % KMAX;
            m_lfsr = step(m_lfsr);
        end
        e = t + 1;
        exp_tog.push_back(e);
        for (int j = 0; j < 2 * k; j++) begin
            l = 1 + int'(m_lfsr[3:0]) % GMAX;
            m_lfsr = step(m_lfsr);
            e = e + l + 1;
            exp_tog.push_back(e);
        end
        m_last_fall = e + SETTLE;
        exp_fall.push_back(m_last_fall);
        m_edges = 2 * k + 1;
    endtask

    task automatic compare_sched(input string tag);
        check({tag, " n_toggles"}, tog_q.size(), exp_tog.size());
        for (int i = 0; i < exp_tog.size() && i < tog_q.size(); i++)
            check($sformatf("%s toggle%0d_cyc", tag, i), tog_q[i], exp_tog[i]);
        check({tag, " n_busy_falls"}, fall_q.size(), exp_fall.size());
        for (int i = 0; i < exp_fall.size() && i < fall_q.size(); i++)
            check($sformatf("%s busy_fall%0d_cyc", tag, i), fall_q[i], exp_fall[i]);
        clear_q();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        m_lfsr = SEED;
        clear_q();
    endtask

    initial begin
        int t, nb, nt;
        logic p;
        reset    = 1'b1;
        data_in  = 1'b1;
        data_in1 = 1'b1;
        m_lfsr   = SEED;

        // reset values
        do_reset(3);
        check("t1 data_out", data_out, 1);
        check("t1 busy", busy, 0);
        check("t1 bounce_edges", bounce_edges, 0);
        check("t1 dut1 data_out", data_out1, 1);

        // single-edge instance: one toggle, busy SETTLE_CYC+1 cycles
        tick();
        data_in1 = 1'b0;
        t  = cyc + 1;
        nb = 0;
        nt = 0;
        p  = data_out1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy1) nb++;
            if (data_out1 != p) nt++;
            p = data_out1;
            if (cyc == t)     check("t2 no_early_toggle", data_out1, 1);
            if (cyc == t + 1) check("t2 latency", data_out1, 0);
        end
        check("t2 busy_cycles", nb, 5);
        check("t2 toggles", nt, 1);
        check("t2 bounce_edges", bounce_edges1, 1);
        check("t2 busy_end", busy1, 0);
        clear_q();

        // default press from seed
        tick();
        data_in = 1'b0;
        t = cyc + 1;
        model_event(t, 1'b1);
        rel3.delete();
        foreach (exp_tog[i]) rel3.push_back(exp_tog[i] - t);
        wait_cyc(m_last_fall + 3);
        compare_sched("t3");
        check("t3 data_out", data_out, 0);
        check("t3 busy", busy, 0);
        check("t3 bounce_edges", bounce_edges, m_edges);
        check("t3 edges_odd", int'(bounce_edges) % 2, 1);

        // release event
        tick();
        data_in = 1'b1;
        t = cyc + 1;
        model_event(t, REL_BURST);
        wait_cyc(m_last_fall + 3);
        compare_sched("t6");
        check("t6 data_out", data_out, 1);
        check("t6 bounce_edges", bounce_edges, m_edges);

        // press, revert mid-burst; release starts one cycle after busy falls
        tick();
        data_in = 1'b0;
        t = cyc + 1;
        model_event(t, 1'b1);
        tick();
        tick();
        data_in = 1'b1;
        model_event(m_last_fall + 1, REL_BURST);
        wait_cyc(m_last_fall + 3);
        compare_sched("t4");
        check("t4 data_out", data_out, 1);
        check("t4 busy", busy, 0);
        check("t4 bounce_edges", bounce_edges, m_edges);

        // reset mid-HOLD, then the seed sequence must reproduce
        do_reset(2);
        tick();
        data_in = 1'b0;
        tick();
        tick();
        check("t5 first_toggle", data_out, 0);
        reset   = 1'b1;
        data_in = 1'b1;
        tick();
        reset = 1'b0;
        check("t5 data_out", data_out, 1);
        check("t5 busy", busy, 0);
        check("t5 bounce_edges", bounce_edges, 0);
        m_lfsr = SEED;
        clear_q();
        tick();
        check("t5 idle_after_reset", busy, 0);
        data_in = 1'b0;
        t = cyc + 1;
        model_event(t, 1'b1);
        wait_cyc(m_last_fall + 3);
        check("t5 n_toggles", tog_q.size(), rel3.size());
        for (int i = 0; i < rel3.size() && i < tog_q.size(); i++)
            check($sformatf("t5 repeat_toggle%0d", i), tog_q[i] - t, rel3[i]);
        check("t5 data_out_end", data_out, 0);
        clear_q();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
